// File: rtl/branch_unit_if.sv
// rtl/branch_unit_if.sv - branch request, target LUT write and branch result bundle
//
// Purpose: groups every signal between the decode/ALU side and branch_unit so
// the resolver is connected through one port.
// Modports:
//   master - drives prog_ctr, br_valid, br_op, lut_idx, zero_flag, neg_flag,
//            lut_we, lut_waddr, lut_wdata; observes branchFlag, target, phase, ras_err
//   slave  - the resolver side (directions mirrored)
interface branch_unit_if #(
    parameter int D      = 12,
    parameter int LUT_AW = 4
);
    logic [D-1:0]      prog_ctr;
    logic              br_valid;
    logic [2:0]        br_op;
    logic [LUT_AW-1:0] lut_idx;
    logic              zero_flag;
    logic              neg_flag;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [D-1:0]      lut_wdata;
    logic              branchFlag;
    logic [D-1:0]      target;
    logic [2:0]        phase;
    logic              ras_err;

    modport master (
        output prog_ctr, br_valid, br_op, lut_idx, zero_flag, neg_flag,
               lut_we, lut_waddr, lut_wdata,
        input  branchFlag, target, phase, ras_err
    );

    modport slave (
        input  prog_ctr, br_valid, br_op, lut_idx, zero_flag, neg_flag,
               lut_we, lut_waddr, lut_wdata,
        output branchFlag, target, phase, ras_err
    );
endinterface

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - slot-aligned branch resolver with target LUT and optional return-address stack
//
// Purpose: captures one branch request per instruction slot, evaluates its
// condition against the sampled flags and presents branchFlag/target to the PC
// during phase 0 of the following slot.
// Optional feature macro: BRANCH_UNIT_RAS_EN (return-address stack for CALL/RET).
// Ports:
//   clk   - clock
//   reset - synchronous, active-high
//   bus   - branch_unit_if.slave: request (prog_ctr, br_valid, br_op, lut_idx,
//           zero_flag, neg_flag), LUT write (lut_we, lut_waddr, lut_wdata),
//           results (branchFlag, target, phase, ras_err)
module branch_unit #(
    parameter int D         = 12,
    parameter int PHASES    = 6,
    parameter int LUT_AW    = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    branch_unit_if.slave bus
);
    localparam logic [2:0] OP_JMP  = 3'b000;
    localparam logic [2:0] OP_BRZ  = 3'b001;
    localparam logic [2:0] OP_BRNZ = 3'b010;
    localparam logic [2:0] OP_BRN  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;

    localparam logic [2:0] PH_LAST = 3'(PHASES - 1);

    logic [2:0]        phase_q, phase_d;
    logic              pend_q;
    logic [2:0]        op_q;
    logic [LUT_AW-1:0] idx_q;
    logic              zero_q;
    logic              neg_q;
    logic              flag_q;
    logic [D-1:0]      tgt_q;
    logic [D-1:0]      lut_q [2**LUT_AW];

    logic              commit;
    logic              taken_d;
    logic [D-1:0]      tgt_d;
    logic              ras_nonempty;
    logic [D-1:0]      ras_top;

    // The edge ending the last phase is the one the PC-facing outputs update on.
    assign commit  = (phase_q == PH_LAST);
    assign phase_d = commit ? 3'd0 : phase_q + 3'd1;

    always_comb begin
        taken_d = 1'b0;
        case (op_q)
            OP_JMP, OP_CALL: taken_d = 1'b1;
            OP_BRZ:          taken_d = zero_q;
            OP_BRNZ:         taken_d = !zero_q;
            OP_BRN:          taken_d = neg_q;
            OP_RET:          taken_d = ras_nonempty;
            default:         taken_d = 1'b0;
        endcase
        if (!pend_q) begin
            taken_d = 1'b0;
        end
        tgt_d = '0;
        if (taken_d) begin
            tgt_d = (op_q == OP_RET) ? ras_top : lut_q[idx_q];
        end
    end

    // Outputs load only from the pending registers, so a request arriving in
    // the commit cycle itself waits for the next slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 3'd0;
            pend_q  <= 1'b0;
            op_q    <= 3'd0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            flag_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            if (commit) begin
                flag_q <= taken_d;
                tgt_q  <= tgt_d;
            end else begin
                flag_q <= 1'b0;
                tgt_q  <= '0;
            end
            if (bus.br_valid) begin
                pend_q <= 1'b1;
                op_q   <= bus.br_op;
                idx_q  <= bus.lut_idx;
                zero_q <= bus.zero_flag;
                neg_q  <= bus.neg_flag;
            end else if (commit) begin
                pend_q <= 1'b0;
            end
        end
    end

    // Target table survives reset; a write on the commit edge is seen by the next commit.
    always_ff @(posedge clk) begin
        if (bus.lut_we) begin
            lut_q[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

`ifdef BRANCH_UNIT_RAS_EN
    localparam int RW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [D-1:0]  ret_q;
    logic [D-1:0]  ras_q [RAS_DEPTH];
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic [CW-1:0] top_sel;
    logic          do_push;
    logic          do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            ret_q <= '0;
        end else if (bus.br_valid) begin
            ret_q <= bus.prog_ctr + D'(1);
        end
    end

    assign top_sel      = cnt_q - CW'(1);
    assign ras_nonempty = (cnt_q != '0);
    assign ras_top      = ras_q[top_sel[RW-1:0]];
    assign do_push      = commit && pend_q && (op_q == OP_CALL);
    assign do_pop       = commit && pend_q && (op_q == OP_RET);

    // Entry 0 is the oldest; a push onto a full stack shifts it out.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (do_push) begin
            if (cnt_q == CW'(RAS_DEPTH)) begin
                for (int i = 0; i < RAS_DEPTH - 1; i++) begin
                    ras_q[i] <= ras_q[i+1];
                end
                ras_q[RAS_DEPTH-1] <= ret_q;
                err_q <= 1'b1;
            end else begin
                ras_q[cnt_q[RW-1:0]] <= ret_q;
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (do_pop) begin
            if (ras_nonempty) begin
                cnt_q <= cnt_q - CW'(1);
            end else begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.ras_err = err_q;
`else
    logic unused_ras_inputs;

    assign ras_nonempty      = 1'b0;
    assign ras_top           = '0;
    assign unused_ras_inputs = ^{bus.prog_ctr, 32'(RAS_DEPTH)};
    assign bus.ras_err       = 1'b0;
`endif

    assign bus.branchFlag = flag_q;
    assign bus.target     = tgt_q;
    assign bus.phase      = phase_q;
endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - scoreboard bench for branch_unit
module tb_branch_unit;
    localparam int D         = 12;
    localparam int PHASES    = 6;
    localparam int LUT_AW    = 4;
    localparam int RAS_DEPTH = 4;

    localparam logic [2:0] JMP  = 3'b000;
    localparam logic [2:0] BRZ  = 3'b001;
    localparam logic [2:0] BRNZ = 3'b010;
    localparam logic [2:0] BRN  = 3'b011;
    localparam logic [2:0] CALL = 3'b100;
    localparam logic [2:0] RET  = 3'b101;

    typedef struct {
        logic         flag;
        logic [D-1:0] tgt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    branch_unit_if #(.D(D), .LUT_AW(LUT_AW)) bus();

    branch_unit #(
        .D(D), .PHASES(PHASES), .LUT_AW(LUT_AW), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    exp_t         sb [$];
    int           m_phase = 0;
    bit           m_pend  = 0;
    logic [2:0]   m_op;
    logic [LUT_AW-1:0] m_idx;
    logic         m_z, m_n;
    logic [D-1:0] m_ret;
    logic [D-1:0] m_lut [2**LUT_AW];
    logic [D-1:0] m_ras [$];
    bit           m_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_commit();
        exp_t e;
        logic t;
        t = 1'b0;
        if (m_pend) begin
            case (m_op)
                JMP, CALL: t = 1'b1;
                BRZ:       t = m_z;
                BRNZ:      t = !m_z;
                BRN:       t = m_n;
                RET: begin
`ifdef BRANCH_UNIT_RAS_EN
                    t = (m_ras.size() > 0);
`else
                    t = 1'b0;
`endif
                end
                default:   t = 1'b0;
            endcase
        end
        e.flag = t;
        e.tgt  = '0;
        if (t) e.tgt = (m_op == RET) ? m_ras[$] : m_lut[m_idx];
`ifdef BRANCH_UNIT_RAS_EN
        if (m_pend && m_op == CALL) begin
            m_ras.push_back(m_ret);
            if (m_ras.size() > RAS_DEPTH) begin
                void'(m_ras.pop_front());
                m_err = 1;
            end
        end
        if (m_pend && m_op == RET) begin
            if (m_ras.size() == 0) m_err = 1;
            else void'(m_ras.pop_back());
        end
`endif
        sb.push_back(e);
        m_pend = 0;
    endtask

    task automatic observe();
        exp_t e;
        check("phase", 32'(bus.phase), 32'(m_phase));
        if (m_phase == 0) begin
            if (sb.size() == 0) begin
                total++;
                $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            end else begin
                e = sb.pop_front();
                check("branchFlag", 32'(bus.branchFlag), 32'(e.flag));
                check("target", 32'(bus.target), 32'(e.tgt));
                check("ras_err", 32'(bus.ras_err), 32'(m_err));
            end
        end else begin
            check("branchFlag_idle", 32'(bus.branchFlag), 32'd0);
            check("target_idle", 32'(bus.target), 32'd0);
        end
    endtask

    // One clock: drive at the negedge, model the edge, then observe at the next negedge.
    task automatic cyc(input logic v, input logic [2:0] op, input logic [LUT_AW-1:0] idx,
                       input logic z, input logic n, input logic [D-1:0] pc,
                       input logic we, input logic [LUT_AW-1:0] wa, input logic [D-1:0] wd);
        bus.br_valid  = v;
        bus.br_op     = op;
        bus.lut_idx   = idx;
        bus.zero_flag = z;
        bus.neg_flag  = n;
        bus.prog_ctr  = pc;
        bus.lut_we    = we;
        bus.lut_waddr = wa;
        bus.lut_wdata = wd;
        if (m_phase == PHASES - 1) model_commit();
        if (v) begin
            m_pend = 1;
            m_op   = op;
            m_idx  = idx;
            m_z    = z;
            m_n    = n;
            m_ret  = pc + D'(1);
        end
        if (we) m_lut[wa] = wd;
        @(posedge clk);
        m_phase = (m_phase == PHASES - 1) ? 0 : m_phase + 1;
        @(negedge clk);
        bus.br_valid = 1'b0;
        bus.lut_we   = 1'b0;
        observe();
    endtask

    task automatic idle(input int k);
        repeat (k) cyc(1'b0, 3'd0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic to_phase(input int p);
        while (m_phase != p) idle(1);
    endtask

    task automatic req(input logic [2:0] op, input logic [LUT_AW-1:0] idx,
                       input logic z, input logic n, input logic [D-1:0] pc);
        cyc(1'b1, op, idx, z, n, pc, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        bus.br_valid = 1'b0;
        bus.lut_we   = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_phase", 32'(bus.phase), 32'd0);
        check("reset_branchFlag", 32'(bus.branchFlag), 32'd0);
        check("reset_target", 32'(bus.target), 32'd0);
        check("reset_ras_err", 32'(bus.ras_err), 32'd0);
        reset   = 1'b0;
        m_phase = 0;
        m_pend  = 0;
        m_err   = 0;
        sb.delete();
        m_ras.delete();
    endtask

    initial begin
        bus.br_valid  = 1'b0;
        bus.br_op     = 3'd0;
        bus.lut_idx   = '0;
        bus.zero_flag = 1'b0;
        bus.neg_flag  = 1'b0;
        bus.prog_ctr  = '0;
        bus.lut_we    = 1'b0;
        bus.lut_waddr = '0;
        bus.lut_wdata = '0;
        @(negedge clk);
        do_reset();

        // Fill the whole target table.
        for (int i = 0; i < 2**LUT_AW; i++) begin
            logic [D-1:0] wd;
            wd = 12'h040 + 12'(i * 12'h035);
            if (i == 3) wd = 12'h2A0;
            if (i == 4) wd = 12'h111;
            cyc(1'b0, 3'd0, '0, 1'b0, 1'b0, '0, 1'b1, 4'(i), wd);
        end

        // JMP in phase 2 appears only in the next phase 0.
        to_phase(2); req(JMP, 4'd3, 1'b0, 1'b0, 12'h010);
        // BRZ not taken, then BRNZ taken.
        to_phase(1); req(BRZ, 4'd1, 1'b0, 1'b0, 12'h020);
        to_phase(1); req(BRNZ, 4'd1, 1'b0, 1'b0, 12'h021);
        // BRZ taken, BRN not taken.
        to_phase(4); req(BRZ, 4'd6, 1'b1, 1'b0, 12'h022);
        to_phase(0); req(BRN, 4'd7, 1'b1, 1'b0, 12'h023);
        // Last request wins; a phase-5 request rolls into the following slot.
        to_phase(1); req(JMP, 4'd2, 1'b0, 1'b0, 12'h030);
        to_phase(3); req(BRN, 4'd5, 1'b0, 1'b1, 12'h031);
        to_phase(5); req(JMP, 4'd2, 1'b0, 1'b0, 12'h032);
        // LUT write on the commit edge: old value this slot, new value next.
        to_phase(2); req(JMP, 4'd4, 1'b0, 1'b0, 12'h040);
        to_phase(5); cyc(1'b0, 3'd0, '0, 1'b0, 1'b0, '0, 1'b1, 4'd4, 12'h222);
        to_phase(2); req(JMP, 4'd4, 1'b0, 1'b0, 12'h041);
        // Reserved opcodes.
        to_phase(1); req(3'b110, 4'd8, 1'b1, 1'b1, 12'h050);
        to_phase(1); req(3'b111, 4'd9, 1'b1, 1'b1, 12'h051);
        // Reset mid-slot drops the pending JMP; LUT contents survive.
        to_phase(2); req(JMP, 4'd3, 1'b0, 1'b0, 12'h060);
        to_phase(3); do_reset();
        idle(PHASES + 1);
        to_phase(2); req(JMP, 4'd3, 1'b0, 1'b0, 12'h061);
        // CALL then RET.
        to_phase(1); req(CALL, 4'd3, 1'b0, 1'b0, 12'h0FF);
        to_phase(1); req(RET, 4'd7, 1'b0, 1'b0, 12'h000);
        // Five CALLs overflow a four-deep stack, then drain past empty.
        to_phase(2); req(CALL, 4'd1, 1'b0, 1'b0, 12'h010);
        to_phase(2); req(CALL, 4'd2, 1'b0, 1'b0, 12'h020);
        to_phase(2); req(CALL, 4'd5, 1'b0, 1'b0, 12'h030);
        to_phase(2); req(CALL, 4'd6, 1'b0, 1'b0, 12'h040);
        to_phase(2); req(CALL, 4'd3, 1'b0, 1'b0, 12'hFFF);
        for (int k = 0; k < 5; k++) begin
            to_phase(3); req(RET, 4'd2, 1'b0, 1'b0, 12'h000);
        end
        idle(2 * PHASES);

        do_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
